// File: rtl/rtc_sched_pkg.sv
// rtc_sched_pkg: shared encodings for the RTC bus scheduler.
//   state_e  - scheduler FSM states
//   job_e    - kind of access currently being served
//   TM_IDLE  - timing-machine control code meaning "no run in progress"
package rtc_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_A_GO,
    S_A_WAIT,
    S_D_GO,
    S_D_WAIT,
    S_NEXT
  } state_e;

  typedef enum logic [1:0] {
    JOB_INIT,
    JOB_WR,
    JOB_SCAN
  } job_e;

  localparam logic [4:0] TM_IDLE = 5'd0;

endpackage

// File: rtl/rtc_watchdog.sv
// rtc_watchdog: loadable 8-bit timeout counter.
//   clk, reset : clock, synchronous active-high reset
//   load       : clear the count (asserted the cycle before a wait state)
//   run        : count while high
//   expired    : count has reached LIMIT while running
module rtc_watchdog #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = 8'd0;
    end else if (run && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign expired = run && (cnt_q == LIMIT);

endmodule

// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler: sequences RTC register accesses through the bus timing
// machine: one init write after reset, then user writes and periodic read
// scans, each as an address-phase run followed by a data-phase run.
//   refresh                  : pulse requesting a read scan
//   wr_req/wr_addr/wr_data   : user write request, held until wr_ack
//   wr_ack                   : pulse when the user write completes
//   tm_start/tm_op/tm_ad     : timing machine I / OP (1=read) / AD (1=address)
//   tm_state                 : timing machine control code, 0 = idle
//   bus_out / bus_in         : value to drive on / sampled from the RTC bus
//   res_we/res_idx/res_data  : result write strobe into the time register file
//   busy / err               : access in progress / sticky timeout flag
module rtc_bus_scheduler
  import rtc_sched_pkg::*;
#(
  parameter logic [7:0]  INIT_ADDR    = 8'h02,
  parameter logic [7:0]  INIT_DATA    = 8'h10,
  parameter logic [7:0]  SCAN_BASE    = 8'h21,
  parameter int unsigned SCAN_LEN     = 6,
  parameter logic [4:0]  CAPTURE_CODE = 5'd16,
  parameter logic [7:0]  TIMEOUT      = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       tm_start,
  output logic       tm_op,
  output logic       tm_ad,
  input  logic [4:0] tm_state,
  output logic [7:0] bus_out,
  input  logic [7:0] bus_in,
  output logic       res_we,
  output logic [2:0] res_idx,
  output logic [7:0] res_data,
  output logic       busy,
  output logic       err
);

  state_e     state_q, state_d;
  job_e       job_q, job_d;
  logic [7:0] cur_addr_q, cur_addr_d, cur_data_q, cur_data_d, rd_byte_q, rd_byte_d;
  logic       cur_op_q, cur_op_d, init_done_q, init_done_d, scan_pend_q, scan_pend_d;
  logic       seen_q, seen_d, cap_done_q, cap_done_d;
  logic [2:0] idx_q, idx_d;
  logic       tm_start_q, tm_start_d, tm_op_q, tm_op_d, tm_ad_q, tm_ad_d;
  logic [7:0] bus_out_q, bus_out_d, res_data_q, res_data_d;
  logic [2:0] res_idx_q, res_idx_d;
  logic       wr_ack_q, wr_ack_d, res_we_q, res_we_d, busy_q, busy_d, err_q, err_d;
  logic       wd_expired;

  rtc_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .load    ((state_q == S_A_GO) || (state_q == S_D_GO)),
    .run     ((state_q == S_A_WAIT) || (state_q == S_D_WAIT)),
    .expired (wd_expired)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    job_d       = job_q;
    cur_addr_d  = cur_addr_q;
    cur_data_d  = cur_data_q;
    cur_op_d    = cur_op_q;
    rd_byte_d   = rd_byte_q;
    init_done_d = init_done_q;
    // A refresh is always remembered; while already pending it is a no-op.
    scan_pend_d = scan_pend_q | refresh;
    seen_d      = seen_q;
    cap_done_d  = cap_done_q;
    idx_d       = idx_q;
    tm_start_d  = 1'b0;
    tm_op_d     = 1'b0;
    tm_ad_d     = 1'b0;
    bus_out_d   = bus_out_q;
    wr_ack_d    = 1'b0;
    res_we_d    = 1'b0;
    res_idx_d   = res_idx_q;
    res_data_d  = res_data_q;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (!init_done_q) begin
          job_d = JOB_INIT; cur_addr_d = INIT_ADDR; cur_data_d = INIT_DATA;
          cur_op_d = 1'b0; state_d = S_A_GO;
        end else if (wr_req && !wr_ack_q) begin
          // wr_ack_q guard: the requester has not yet seen the ack of the
          // write that just finished, so its wr_req is still the old one.
          job_d = JOB_WR; cur_addr_d = wr_addr; cur_data_d = wr_data;
          cur_op_d = 1'b0; state_d = S_A_GO;
        end else if (scan_pend_q || refresh) begin
          job_d = JOB_SCAN; cur_addr_d = SCAN_BASE; cur_op_d = 1'b1;
          idx_d = 3'd0; state_d = S_A_GO;
        end
      end
      S_A_GO: begin
        tm_start_d = 1'b1;
        tm_ad_d    = 1'b1;
        bus_out_d  = cur_addr_q;
        seen_d     = 1'b0;
        state_d    = S_A_WAIT;
      end
      S_D_GO: begin
        tm_start_d = 1'b1;
        tm_op_d    = cur_op_q;
        if (!cur_op_q) bus_out_d = cur_data_q;
        seen_d     = 1'b0;
        cap_done_d = 1'b0;
        state_d    = S_D_WAIT;
      end
      S_A_WAIT, S_D_WAIT: begin
        if (wd_expired) begin
          err_d       = 1'b1;
          scan_pend_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          if ((state_q == S_D_WAIT) && cur_op_q && !cap_done_q &&
              (tm_state == CAPTURE_CODE)) begin
            rd_byte_d  = bus_in;
            cap_done_d = 1'b1;
          end
          // A run is complete only once it has been seen to leave idle.
          if (tm_state != TM_IDLE) seen_d = 1'b1;
          else if (seen_q)         state_d = (state_q == S_A_WAIT) ? S_D_GO : S_NEXT;
        end
      end
      S_NEXT: begin
        case (job_q)
          JOB_SCAN: begin
            res_we_d   = 1'b1;
            res_idx_d  = idx_q;
            res_data_d = rd_byte_q;
            if (idx_q == 3'(SCAN_LEN - 1)) begin
              scan_pend_d = 1'b0;
              state_d     = S_IDLE;
            end else begin
              idx_d      = idx_q + 3'd1;
              cur_addr_d = cur_addr_q + 8'd1;
              state_d    = S_A_GO;
            end
          end
          JOB_WR: begin
            wr_ack_d = 1'b1;
            state_d  = S_IDLE;
          end
          default: begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;       job_q <= JOB_INIT;
      cur_addr_q <= 8'd0;      cur_data_q <= 8'd0;    cur_op_q <= 1'b0;
      rd_byte_q <= 8'd0;       init_done_q <= 1'b0;   scan_pend_q <= 1'b0;
      seen_q <= 1'b0;          cap_done_q <= 1'b0;    idx_q <= 3'd0;
      tm_start_q <= 1'b0;      tm_op_q <= 1'b0;       tm_ad_q <= 1'b0;
      bus_out_q <= 8'd0;       wr_ack_q <= 1'b0;      res_we_q <= 1'b0;
      res_idx_q <= 3'd0;       res_data_q <= 8'd0;    busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;      job_q <= job_d;
      cur_addr_q <= cur_addr_d; cur_data_q <= cur_data_d; cur_op_q <= cur_op_d;
      rd_byte_q <= rd_byte_d;  init_done_q <= init_done_d; scan_pend_q <= scan_pend_d;
      seen_q <= seen_d;        cap_done_q <= cap_done_d; idx_q <= idx_d;
      tm_start_q <= tm_start_d; tm_op_q <= tm_op_d;   tm_ad_q <= tm_ad_d;
      bus_out_q <= bus_out_d;  wr_ack_q <= wr_ack_d;  res_we_q <= res_we_d;
      res_idx_q <= res_idx_d;  res_data_q <= res_data_d; busy_q <= busy_d;
      err_q <= err_d;
    end
  end

  assign tm_start = tm_start_q;
  assign tm_op    = tm_op_q;
  assign tm_ad    = tm_ad_q;
  assign bus_out  = bus_out_q;
  assign wr_ack   = wr_ack_q;
  assign res_we   = res_we_q;
  assign res_idx  = res_idx_q;
  assign res_data = res_data_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// tb_rtc_bus_scheduler: scoreboard bench for rtc_bus_scheduler with a small
// behavioural timing-machine model.
module tb_rtc_bus_scheduler;

  logic       clk = 1'b0;
  logic       reset, refresh, wr_req;
  logic [7:0] wr_addr, wr_data, bus_in, bus_out, res_data;
  logic [4:0] tm_state = 5'd0;
  logic       wr_ack, tm_start, tm_op, tm_ad, res_we, busy, err;
  logic [2:0] res_idx;

  always #5 clk = ~clk;

  rtc_bus_scheduler dut (
    .clk(clk), .reset(reset), .refresh(refresh), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .tm_start(tm_start), .tm_op(tm_op), .tm_ad(tm_ad), .tm_state(tm_state),
    .bus_out(bus_out), .bus_in(bus_in), .res_we(res_we), .res_idx(res_idx),
    .res_data(res_data), .busy(busy), .err(err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- timing machine model ----------------
  // A run walks codes 1, 8, 16, 20 then returns to idle. During a read data
  // phase at code 16 it presents 8'h30 + (address - 8'h21).
  logic       stuck = 1'b0, running = 1'b0, rd_phase = 1'b0;
  int         pos = 0;
  logic [7:0] addr_reg = 8'd0;
  logic [4:0] codes [4] = '{5'd1, 5'd8, 5'd16, 5'd20};

  always @(posedge clk) begin
    if (stuck) begin
      tm_state <= 5'd3;
      running  <= 1'b0;
    end else if (tm_start) begin
      tm_state <= codes[0];
      pos      <= 1;
      running  <= 1'b1;
      rd_phase <= !tm_ad && tm_op;
      if (tm_ad) addr_reg <= bus_out;
    end else if (running) begin
      if (pos == 4) begin
        tm_state <= 5'd0;
        running  <= 1'b0;
      end else begin
        tm_state <= codes[pos];
        pos      <= pos + 1;
      end
    end else begin
      tm_state <= 5'd0;
    end
  end

  assign bus_in = (tm_state == 5'd16 && rd_phase) ? 8'h30 + (addr_reg - 8'h21) : 8'hEE;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic       ad;
    logic       chk_op;
    logic       op;
    logic [7:0] bus;
  } start_t;
  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] data;
  } res_t;

  start_t exp_start_q[$];
  res_t   exp_res_q[$];
  int     exp_ack = 0;
  logic   prev_start = 1'b0;

  function automatic void push_start(logic ad, logic chk_op, logic op, logic [7:0] bus);
    start_t s;
    s.ad = ad; s.chk_op = chk_op; s.op = op; s.bus = bus;
    exp_start_q.push_back(s);
  endfunction

  function automatic void push_write(logic [7:0] a, logic [7:0] d);
    push_start(1'b1, 1'b0, 1'b0, a);
    push_start(1'b0, 1'b1, 1'b0, d);
    exp_ack++;
  endfunction

  function automatic void push_scan_entry(int i, logic with_res);
    res_t r;
    push_start(1'b1, 1'b0, 1'b0, 8'(8'h21 + i));
    push_start(1'b0, 1'b1, 1'b1, 8'(8'h21 + i));
    if (with_res) begin
      r.idx = 3'(i); r.data = 8'(8'h30 + i);
      exp_res_q.push_back(r);
    end
  endfunction

  function automatic void push_scan();
    for (int i = 0; i < 6; i++) push_scan_entry(i, 1'b1);
  endfunction

  // Monitor: compares each DUT event against the head of its queue.
  always @(negedge clk) begin
    if (reset) begin
      prev_start = 1'b0;
    end else begin
      if (tm_start) begin
        start_t s;
        check("tm_start_one_cycle", {31'd0, prev_start}, 32'd0);
        check("start_expected", {31'd0, exp_start_q.size() != 0}, 32'd1);
        if (exp_start_q.size() != 0) begin
          s = exp_start_q.pop_front();
          check("tm_ad", {31'd0, tm_ad}, {31'd0, s.ad});
          check("bus_out_at_start", {24'd0, bus_out}, {24'd0, s.bus});
          if (s.chk_op) check("tm_op", {31'd0, tm_op}, {31'd0, s.op});
        end
      end
      if (res_we) begin
        res_t r;
        check("res_expected", {31'd0, exp_res_q.size() != 0}, 32'd1);
        if (exp_res_q.size() != 0) begin
          r = exp_res_q.pop_front();
          check("res_idx", {29'd0, res_idx}, {29'd0, r.idx});
          check("res_data", {24'd0, res_data}, {24'd0, r.data});
        end
      end
      if (wr_ack) begin
        check("ack_expected", {31'd0, exp_ack > 0}, 32'd1);
        if (exp_ack > 0) exp_ack--;
      end
      prev_start = tm_start;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_start_q.size() != 0 || exp_res_q.size() != 0 || exp_ack != 0 || busy)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completed_in_budget"}, {31'd0, n < budget}, 32'd1);
    check({name, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_ack(input string name, input int budget);
    int n = 0;
    while (!wr_ack && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_wr_ack_seen"}, {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
  endtask

  task automatic check_cleared(input string name);
    check({name, "_tm_start"}, {31'd0, tm_start}, 32'd0);
    check({name, "_tm_ad_op"}, {30'd0, tm_ad, tm_op}, 32'd0);
    check({name, "_bus_out"}, {24'd0, bus_out}, 32'd0);
    check({name, "_ack_we"}, {30'd0, wr_ack, res_we}, 32'd0);
    check({name, "_res_idx_data"}, {21'd0, res_idx, res_data}, 32'd0);
    check({name, "_busy_err"}, {30'd0, busy, err}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1; refresh = 1'b0; wr_req = 1'b0; wr_addr = 8'd0; wr_data = 8'd0;
    repeat (3) @(negedge clk);
    check_cleared("reset");

    // Init write after reset.
    push_start(1'b1, 1'b0, 1'b0, 8'h02);
    push_start(1'b0, 1'b1, 1'b0, 8'h10);
    reset = 1'b0;
    wait_done("init", 200);
    check("err_after_init", {31'd0, err}, 32'd0);

    // Read scan.
    push_scan();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    wait_done("scan", 400);

    // User write while idle.
    push_write(8'h23, 8'h59);
    wr_addr = 8'h23; wr_data = 8'h59; wr_req = 1'b1;
    wait_ack("write", 200);
    wait_done("write", 50);

    // Write and refresh in the same cycle: write first, then full scan.
    push_write(8'h3A, 8'h0F);
    push_scan();
    wr_addr = 8'h3A; wr_data = 8'h0F; wr_req = 1'b1; refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    wait_ack("wr_plus_refresh", 200);
    wait_done("wr_plus_refresh", 400);
    check("err_before_timeout", {31'd0, err}, 32'd0);

    // Stuck timing machine: timeout, then the held write retries.
    stuck = 1'b1;
    push_start(1'b1, 1'b0, 1'b0, 8'h44);
    push_write(8'h44, 8'h77);
    wr_addr = 8'h44; wr_data = 8'h77; wr_req = 1'b1;
    n = 0;
    while (!err && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("timeout_err_set", {31'd0, err}, 32'd1);
    check("timeout_cycle_window", {31'd0, (n >= 256) && (n <= 260)}, 32'd1);
    check("timeout_back_to_idle", {31'd0, busy}, 32'd0);
    stuck = 1'b0;
    wait_ack("retry", 200);
    wait_done("retry", 50);
    check("err_sticky", {31'd0, err}, 32'd1);

    // Reset in the middle of a scan at index 3.
    for (int i = 0; i < 3; i++) push_scan_entry(i, 1'b1);
    push_start(1'b1, 1'b0, 1'b0, 8'h24);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    n = 0;
    while (exp_start_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reached_index3", {31'd0, n < 300}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_cleared("midscan_reset");
    push_start(1'b1, 1'b0, 1'b0, 8'h02);
    push_start(1'b0, 1'b1, 1'b0, 8'h10);
    reset = 1'b0;
    wait_done("init_rerun", 200);
    repeat (20) @(negedge clk);
    check("no_stale_events", {31'd0, exp_res_q.size() == 0 && exp_start_q.size() == 0}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
